// File: rtl/pulse_stretcher_pkg.sv
// Shared definitions for board-output pulse drivers: FSM encoding and a timer sizing helper.
package pulse_stretcher_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ON   = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StOn   = ST_ON,
    StGap  = ST_GAP
  } state_e;

  // Bits needed to hold max(on_ticks, off_ticks) - 1, never less than one.
  function automatic int unsigned timer_width(input int unsigned on_ticks,
                                               input int unsigned off_ticks);
    int unsigned m;
    int unsigned w;
    m = (on_ticks > off_ticks) ? on_ticks : off_ticks;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pulse_stretcher_timer.sv
// Loadable down-counter that stops at zero, with a registered done flag (count == 0).
module pulse_timer #(
  parameter int unsigned Width = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             done_o
);

  logic [Width-1:0] count_q, count_d;
  logic             done_q;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      done_q  <= 1'b1;
    end else begin
      count_q <= count_d;
      done_q  <= (count_d == '0);
    end
  end

  assign done_o = done_q;

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle event ticks into fixed-width pulses separated by a fixed low gap,
// queueing ticks that arrive mid-pulse in a saturating counter and replaying each one.
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int unsigned ON_TICKS  = 4,
  parameter int unsigned OFF_TICKS = 2,
  parameter int unsigned CNT_W     = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_in,
  output logic             led_out,
  output logic             busy,
  output logic [CNT_W-1:0] pending,
  output logic             overflow
);

  localparam int unsigned TimerW = timer_width(ON_TICKS, OFF_TICKS);
  localparam logic [TimerW-1:0] OnLoad  = TimerW'(ON_TICKS - 1);
  localparam logic [TimerW-1:0] OffLoad = TimerW'(OFF_TICKS - 1);
  localparam logic [CNT_W-1:0]  PendMax = '1;

  state_e           state_q, state_d;
  logic             led_q, busy_q, overflow_q, overflow_d;
  logic [CNT_W-1:0] pending_q, pending_d;

  logic              tmr_load, tmr_dec, tmr_done;
  logic [TimerW-1:0] tmr_val;
  logic              queue_tick;

  pulse_timer #(
    .Width (TimerW)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .done_o     (tmr_done)
  );

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    overflow_d = overflow_q;
    tmr_load   = 1'b0;
    tmr_val    = OnLoad;
    tmr_dec    = 1'b0;
    queue_tick = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (tick_in) begin
          state_d  = StOn;
          tmr_load = 1'b1;
          tmr_val  = OnLoad;
        end
      end
      StOn: begin
        queue_tick = tick_in;
        if (tmr_done) begin
          state_d  = StGap;
          tmr_load = 1'b1;
          tmr_val  = OffLoad;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      StGap: begin
        if (tmr_done) begin
          if ((pending_q != '0) || tick_in) begin
            // A tick here is consumed together with one queued event: net-zero change.
            state_d   = StOn;
            tmr_load  = 1'b1;
            tmr_val   = OnLoad;
            pending_d = pending_q + CNT_W'(tick_in) - CNT_W'(1);
          end else begin
            state_d = StIdle;
          end
        end else begin
          tmr_dec    = 1'b1;
          queue_tick = tick_in;
        end
      end
      default: state_d = StIdle;
    endcase

    if (queue_tick) begin
      if (pending_q == PendMax) begin
        overflow_d = 1'b1;
      end else begin
        pending_d = pending_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      led_q      <= 1'b0;
      busy_q     <= 1'b0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      led_q      <= (state_d == StOn);
      busy_q     <= (state_d != StIdle);
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign led_out  = led_q;
  assign busy     = busy_q;
  assign pending  = pending_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher (ON_TICKS=4, OFF_TICKS=2, CNT_W=2).
module tb_pulse_stretcher;

  logic       clk;
  logic       reset;
  logic       tick_in;
  logic       led_out;
  logic       busy;
  logic [1:0] pending;
  logic       overflow;

  int compared;
  int mismatched;

  typedef struct packed {
    logic       tick;
    logic       rst;
    logic       exp_led;
    logic       exp_busy;
    logic [1:0] exp_pend;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[$];

  pulse_stretcher #(
    .ON_TICKS  (4),
    .OFF_TICKS (2),
    .CNT_W     (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .tick_in  (tick_in),
    .led_out  (led_out),
    .busy     (busy),
    .pending  (pending),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic t, input logic r, input logic l, input logic b,
                     input logic [1:0] p, input logic o);
    vec_t v;
    v.tick = t; v.rst = r; v.exp_led = l; v.exp_busy = b; v.exp_pend = p; v.exp_ovf = o;
    vecs.push_back(v);
  endtask

  task automatic addn(input int n, input logic t, input logic r, input logic l, input logic b,
                      input logic [1:0] p, input logic o);
    for (int i = 0; i < n; i++) add(t, r, l, b, p, o);
  endtask

  task automatic step(input logic t, input logic r);
    tick_in = t;
    reset   = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got {led,busy,pend,ovf}=%b required %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  initial begin
    int rises;
    int cycles;
    logic prev;
    compared   = 0;
    mismatched = 0;
    tick_in    = 1'b0;
    reset      = 1'b1;

    // Reset state.
    addn(2, 0, 1, 0, 0, 2'd0, 0);
    // Single tick: 4 high, 2 gap, then idle.
    add(1, 0, 1, 1, 2'd0, 0);
    addn(3, 0, 0, 1, 1, 2'd0, 0);
    addn(2, 0, 0, 0, 1, 2'd0, 0);
    add(0, 0, 0, 0, 2'd0, 0);
    // Tick on the last gap cycle with nothing queued.
    add(1, 0, 1, 1, 2'd0, 0);
    addn(3, 0, 0, 1, 1, 2'd0, 0);
    addn(2, 0, 0, 0, 1, 2'd0, 0);
    add(1, 0, 1, 1, 2'd0, 0);
    addn(3, 0, 0, 1, 1, 2'd0, 0);
    addn(2, 0, 0, 0, 1, 2'd0, 0);
    add(0, 0, 0, 0, 2'd0, 0);
    // Ticks at 0, 2, 3: three separated pulses, pending peaks at 2.
    add(1, 0, 1, 1, 2'd0, 0);
    add(0, 0, 1, 1, 2'd0, 0);
    add(1, 0, 1, 1, 2'd1, 0);
    add(1, 0, 1, 1, 2'd2, 0);
    addn(2, 0, 0, 0, 1, 2'd2, 0);
    addn(4, 0, 0, 1, 1, 2'd1, 0);
    addn(2, 0, 0, 0, 1, 2'd1, 0);
    addn(4, 0, 0, 1, 1, 2'd0, 0);
    addn(2, 0, 0, 0, 1, 2'd0, 0);
    add(0, 0, 0, 0, 2'd0, 0);
    // Five-cycle tick burst: saturate, drop the fifth, replay four pulses.
    add(1, 0, 1, 1, 2'd0, 0);
    add(1, 0, 1, 1, 2'd1, 0);
    add(1, 0, 1, 1, 2'd2, 0);
    add(1, 0, 1, 1, 2'd3, 0);
    add(1, 0, 0, 1, 2'd3, 1);
    add(0, 0, 0, 1, 2'd3, 1);
    addn(4, 0, 0, 1, 1, 2'd2, 1);
    addn(2, 0, 0, 0, 1, 2'd2, 1);
    addn(4, 0, 0, 1, 1, 2'd1, 1);
    addn(2, 0, 0, 0, 1, 2'd1, 1);
    addn(4, 0, 0, 1, 1, 2'd0, 1);
    addn(2, 0, 0, 0, 1, 2'd0, 1);
    addn(2, 0, 0, 0, 0, 2'd0, 1);
    // Tick together with reset is discarded; reset clears sticky overflow.
    add(1, 1, 0, 0, 2'd0, 0);
    add(0, 0, 0, 0, 2'd0, 0);
    // Reset mid-pulse with one queued event: truncated, nothing replayed.
    add(1, 0, 1, 1, 2'd0, 0);
    add(1, 0, 1, 1, 2'd1, 0);
    add(0, 1, 0, 0, 2'd0, 0);
    addn(2, 0, 0, 0, 0, 2'd0, 0);
    add(1, 0, 1, 1, 2'd0, 0);
    addn(3, 0, 0, 1, 1, 2'd0, 0);
    addn(2, 0, 0, 0, 1, 2'd0, 0);
    add(0, 0, 0, 0, 2'd0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].tick, vecs[i].rst);
      check($sformatf("vec%0d", i), {led_out, busy, pending, overflow},
            {vecs[i].exp_led, vecs[i].exp_busy, vecs[i].exp_pend, vecs[i].exp_ovf});
    end

    // Saturated queue plus tick on the last gap cycle: net zero, no overflow.
    repeat (4) step(1'b1, 1'b0);
    check("sat_fill", {led_out, busy, pending, overflow}, {1'b1, 1'b1, 2'd3, 1'b0});
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("sat_gap_last", {led_out, busy, pending, overflow}, {1'b0, 1'b1, 2'd3, 1'b0});
    step(1'b1, 1'b0);
    check("sat_net_zero", {led_out, busy, pending, overflow}, {1'b1, 1'b1, 2'd3, 1'b0});
    step(1'b1, 1'b0);
    check("sat_drop", {led_out, busy, pending, overflow}, {1'b1, 1'b1, 2'd3, 1'b1});

    // Drain: three more separate pulses must follow the current one.
    rises  = 0;
    cycles = 0;
    prev   = led_out;
    while (busy && cycles < 60) begin
      step(1'b0, 1'b0);
      if (led_out && !prev) rises++;
      prev = led_out;
      cycles++;
    end
    check_int("drain_timeout", int'(busy), 0);
    check_int("drain_pulses", rises, 3);
    check_int("ovf_sticky", int'(overflow), 1);
    step(1'b0, 1'b1);
    check("final_reset", {led_out, busy, pending, overflow}, {1'b0, 1'b0, 2'd0, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
